// File: rtl/phase_operand_sequencer.sv
// Slot-sequenced register-output mux: latches per-slot select codes on start and
// drives one selected source onto registor_output per unstalled cycle.
module phase_operand_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NSRC      = 4,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned SLOTS     = 3,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned HOLD_LAST = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SLOTS*SEL_W-1:0]   sel_codes,
    input  logic                     stall,
    input  logic [NSRC*WIDTH-1:0]    src_data,
    output logic                     busy,
    output logic [IDX_W-1:0]         slot_idx,
    output logic [WIDTH-1:0]         registor_output,
    output logic                     out_valid,
    output logic                     done,
    output logic                     sel_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [SLOTS*SEL_W-1:0]   codes_q, codes_d;
    logic [IDX_W-1:0]         slot_idx_q, slot_idx_d;
    logic [WIDTH-1:0]         out_q, out_d;
    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;
    logic                     sel_err_q, sel_err_d;

    logic [SEL_W-1:0]         cur_code;
    logic [WIDTH-1:0]         sel_val;
    logic                     code_bad;
    logic                     last_slot;

    // Code of the slot under the pointer and the source it names (code c -> source c-1).
    always_comb begin
        cur_code = '0;
        for (int k = 0; k < int'(SLOTS); k++) begin
            if (slot_idx_q == IDX_W'(k)) begin
                cur_code = codes_q[k*SEL_W +: SEL_W];
            end
        end
        sel_val = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (32'(cur_code) == 32'(i + 1)) begin
                sel_val = src_data[i*WIDTH +: WIDTH];
            end
        end
        code_bad  = 32'(cur_code) > NSRC;
        last_slot = slot_idx_q == IDX_W'(SLOTS - 1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        codes_d     = codes_q;
        slot_idx_d  = slot_idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        sel_err_d   = sel_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    codes_d    = sel_codes;
                    sel_err_d  = 1'b0;
                    slot_idx_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (cur_code != '0 && !code_bad) begin
                        out_d       = sel_val;
                        out_valid_d = 1'b1;
                    end else begin
                        if (HOLD_LAST == 0) begin
                            out_d = '0;
                        end
                        if (code_bad) begin
                            sel_err_d = 1'b1;
                        end
                    end
                    if (last_slot) begin
                        slot_idx_d = '0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        slot_idx_d = slot_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            codes_q     <= '0;
            slot_idx_q  <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            codes_q     <= codes_d;
            slot_idx_q  <= slot_idx_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign busy            = busy_q;
    assign slot_idx        = slot_idx_q;
    assign registor_output = out_q;
    assign out_valid       = out_valid_q;
    assign done            = done_q;
    assign sel_err         = sel_err_q;

endmodule

// File: tb/tb_phase_operand_sequencer.sv
// Directed bench for phase_operand_sequencer; a HOLD_LAST=1 twin shares the stimulus.
module tb_phase_operand_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NSRC  = 4;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned SLOTS = 3;
    localparam int unsigned IDX_W = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic                    stall = 1'b0;
    logic [SLOTS*SEL_W-1:0]  sel_codes = '0;
    logic [NSRC*WIDTH-1:0]   src_data;
    logic [WIDTH-1:0]        eip_r   = 32'h0000_0100;
    logic [WIDTH-1:0]        ebp_r   = 32'h0000_3FF0;
    logic [WIDTH-1:0]        esp_r   = 32'h0000_3FFC;
    logic [WIDTH-1:0]        stack_r = 32'h0000_4000;

    logic                    busy, out_valid, done, sel_err;
    logic [IDX_W-1:0]        slot_idx;
    logic [WIDTH-1:0]        registor_output;
    logic                    h_busy, h_out_valid, h_done, h_sel_err;
    logic [IDX_W-1:0]        h_slot_idx;
    logic [WIDTH-1:0]        h_registor_output;

    int checks = 0;
    int errors = 0;

    // code 1=eip, 2=ebp, 3=esp, 4=stack
    assign src_data = {stack_r, esp_r, ebp_r, eip_r};

    always #5 clock = ~clock;

    phase_operand_sequencer #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .SLOTS(SLOTS), .IDX_W(IDX_W), .HOLD_LAST(0)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .sel_codes(sel_codes), .stall(stall),
        .src_data(src_data), .busy(busy), .slot_idx(slot_idx),
        .registor_output(registor_output), .out_valid(out_valid), .done(done), .sel_err(sel_err)
    );

    phase_operand_sequencer #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .SLOTS(SLOTS), .IDX_W(IDX_W), .HOLD_LAST(1)
    ) dut_hold (
        .clock(clock), .reset(reset), .start(start), .sel_codes(sel_codes), .stall(stall),
        .src_data(src_data), .busy(h_busy), .slot_idx(h_slot_idx),
        .registor_output(h_registor_output), .out_valid(h_out_valid), .done(h_done),
        .sel_err(h_sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [SLOTS*SEL_W-1:0] codes3(input logic [3:0] s0, input logic [3:0] s1,
                                                      input logic [3:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic chk_out(input string tag, input logic [31:0] o, input logic v, input logic d);
        chk({tag, "_out"}, registor_output, o);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idx", 32'(slot_idx), 0);
        chk("rst_out", registor_output, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(sel_err), 0);
        reset = 1'b0;
        stall = 1'b1;
        tick();
        chk("idle_stall_busy", 32'(busy), 0);
        stall = 1'b0;

        // basic sequence: ebp, esp, stack
        sel_codes = codes3(4'd2, 4'd3, 4'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s2_busy", 32'(busy), 1);
        chk("s2_idx0", 32'(slot_idx), 0);
        chk("s2_novalid", 32'(out_valid), 0);
        tick();
        chk_out("s2_slot0", 32'h3FF0, 1'b1, 1'b0);
        chk("s2_idx1", 32'(slot_idx), 1);
        tick();
        chk_out("s2_slot1", 32'h3FFC, 1'b1, 1'b0);
        tick();
        chk_out("s2_slot2", 32'h4000, 1'b1, 1'b1);
        chk("s2_busy_end", 32'(busy), 0);
        chk("s2_idx_end", 32'(slot_idx), 0);
        tick();
        chk("s2_done_pulse", 32'(done), 0);
        chk("s2_persist", registor_output, 32'h4000);

        // code 0 slots: zero vs hold-last
        sel_codes = codes3(4'd0, 4'd3, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_out("s3_slot0", 32'h0, 1'b0, 1'b0);
        chk("s3_h_slot0", h_registor_output, 32'h4000);
        tick();
        chk_out("s3_slot1", 32'h3FFC, 1'b1, 1'b0);
        chk("s3_h_slot1", h_registor_output, 32'h3FFC);
        tick();
        chk_out("s3_slot2", 32'h0, 1'b0, 1'b1);
        chk("s3_h_slot2", h_registor_output, 32'h3FFC);
        chk("s3_h_done", 32'(h_done), 1);

        // reset mid-sequence at slot 1
        sel_codes = codes3(4'd7, 4'd2, 4'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("s1_err_set", 32'(sel_err), 1);
        chk("s1_idx1", 32'(slot_idx), 1);
        chk("s1_h_hold", h_registor_output, 32'h3FFC);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s1_busy", 32'(busy), 0);
        chk("s1_idx", 32'(slot_idx), 0);
        chk("s1_h_out", h_registor_output, 0);
        chk_out("s1", 32'h0, 1'b0, 1'b0);
        chk("s1_err", 32'(sel_err), 0);
        tick();
        chk("s1_no_done", 32'(done), 0);
        chk("s1_still_idle", 32'(busy), 0);

        // stall two cycles at slot 1 while esp changes
        sel_codes = codes3(4'd2, 4'd3, 4'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_out("s4_slot0", 32'h3FF0, 1'b1, 1'b0);
        stall = 1'b1;
        tick();
        chk_out("s4_stall0", 32'h3FF0, 1'b0, 1'b0);
        chk("s4_stall_idx", 32'(slot_idx), 1);
        esp_r = 32'h3FF8;
        tick();
        chk_out("s4_stall1", 32'h3FF0, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        chk_out("s4_slot1", 32'h3FF8, 1'b1, 1'b0);
        tick();
        chk_out("s4_slot2", 32'h4000, 1'b1, 1'b1);

        // bad code, ignored start during RUN, then back-to-back restart
        sel_codes = codes3(4'd7, 4'd1, 4'd4);
        start = 1'b1;
        tick();
        sel_codes = codes3(4'd3, 4'd3, 4'd3);
        tick();
        chk_out("s5_slot0", 32'h0, 1'b0, 1'b0);
        chk("s5_err0", 32'(sel_err), 1);
        chk("s5_busy", 32'(busy), 1);
        tick();
        chk_out("s5_slot1", 32'h100, 1'b1, 1'b0);
        tick();
        chk_out("s5_slot2", 32'h4000, 1'b1, 1'b1);
        chk("s5_err_done", 32'(sel_err), 1);
        stall = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b0;
        chk("s6_busy", 32'(busy), 1);
        chk("s6_err_clr", 32'(sel_err), 0);
        chk("s6_idx", 32'(slot_idx), 0);
        tick();
        chk_out("s6_slot0", 32'h3FF8, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("s6_slot2", 32'h3FF8, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
